// File: rtl/uart_trx.sv
// Full-duplex UART transceiver: configurable frame format, valid/ready transmit side,
// receive FIFO with first-word-fall-through head and sticky line-error flags.
module uart_trx #(
    parameter int  ClkFrequency = 12000000,
    parameter int  Baud         = 2000000,
    parameter int  DataBits     = 8,
    parameter int  Parity       = 0,
    parameter int  StopBits     = 1,
    parameter int  RxFifoDepth  = 16,
    localparam int AW           = $clog2(RxFifoDepth)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DataBits-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                TxD,
    input  logic                RxD,
    output logic [DataBits-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [AW:0]         rx_count,
    output logic                rx_frame_err,
    output logic                rx_parity_err,
    output logic                rx_overrun,
    input  logic                err_clear
);
    localparam int BitCycles = (ClkFrequency + Baud / 2) / Baud;
    localparam int CW        = $clog2(BitCycles);
    localparam int IW        = $clog2(DataBits);

    localparam logic [CW-1:0] CntBit   = CW'(BitCycles - 1);
    localparam logic [CW-1:0] CntHalf  = CW'(BitCycles / 2 - 1);
    localparam logic [IW-1:0] LastBit  = IW'(DataBits - 1);
    localparam logic          LastStop = (StopBits == 2);
    localparam logic          ParityOn = (Parity != 0);

    if (BitCycles < 4) begin : gBitCyclesCheck
        $error("uart_trx: BitCycles = %0d, must be at least 4", BitCycles);
    end
    if (DataBits < 5 || DataBits > 9 || Parity < 0 || Parity > 2 ||
        StopBits < 1 || StopBits > 2) begin : gFormatCheck
        $error("uart_trx: unsupported frame format");
    end
    if (RxFifoDepth < 2 || (1 << AW) != RxFifoDepth) begin : gFifoCheck
        $error("uart_trx: RxFifoDepth must be a power of two >= 2");
    end

    typedef enum logic [2:0] {Idle, Start, Data, Par, Stop} uartState;

    function automatic logic parityOf(input logic [DataBits-1:0] d);
        return (Parity == 2) ? ~(^d) : ^d;
    endfunction

    // ---------------------------------------------------------------- transmitter
    uartState            txState, txStateNext;
    logic [CW-1:0]       txCnt, txCntNext;
    logic [IW-1:0]       txIdx, txIdxNext;
    logic [DataBits-1:0] txShift, txShiftNext;
    logic                txPar, txParNext;
    logic                txStopIdx, txStopIdxNext;
    logic                txdNext;

    assign tx_ready = (txState == Idle);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            txState   <= Idle;
            txCnt     <= '0;
            txIdx     <= '0;
            txShift   <= '0;
            txPar     <= 1'b0;
            txStopIdx <= 1'b0;
            TxD       <= 1'b1;
        end else begin
            txState   <= txStateNext;
            txCnt     <= txCntNext;
            txIdx     <= txIdxNext;
            txShift   <= txShiftNext;
            txPar     <= txParNext;
            txStopIdx <= txStopIdxNext;
            TxD       <= txdNext;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
        txStateNext   = txState;
        txCntNext     = txCnt - 1'b1;
        txIdxNext     = txIdx;
        txShiftNext   = txShift;
        txParNext     = txPar;
        txStopIdxNext = txStopIdx;
        txdNext       = TxD;
        case (txState)
            Idle: begin
                txCntNext = txCnt;
                if (tx_valid) begin
                    txStateNext   = Start;
                    txCntNext     = CntBit;
                    txShiftNext   = tx_data;
                    txParNext     = parityOf(tx_data);
                    txIdxNext     = '0;
                    txStopIdxNext = 1'b0;
                    txdNext       = 1'b0;
                end
            end
            Start: if (txCnt == '0) begin
                txStateNext = Data;
                txCntNext   = CntBit;
                txdNext     = txShift[0];
            end
            Data: if (txCnt == '0) begin
                txCntNext = CntBit;
                if (txIdx == LastBit) begin
                    txStateNext = ParityOn ? Par : Stop;
                    txdNext     = ParityOn ? txPar : 1'b1;
                end else begin
                    txIdxNext   = txIdx + 1'b1;
                    txShiftNext = txShift >> 1;
                    txdNext     = txShift[1];
                end
            end
            Par: if (txCnt == '0) begin
                txStateNext = Stop;
                txCntNext   = CntBit;
                txdNext     = 1'b1;
            end
            Stop: if (txCnt == '0) begin
                txCntNext = CntBit;
                txdNext   = 1'b1;
                if (txStopIdx == LastStop) txStateNext = Idle;
                else                       txStopIdxNext = 1'b1;
            end
            default: txStateNext = Idle;
        endcase
    end

    // ------------------------------------------------------------------- receiver
    logic                rxSync1, rxSync2;
    uartState            rxState, rxStateNext;
    logic [CW-1:0]       rxCnt, rxCntNext;
    logic [IW-1:0]       rxIdx, rxIdxNext;
    logic [DataBits-1:0] rxShift, rxShiftNext;
    logic                rxPar, rxParNext;
    logic                frameDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
            rxState <= Idle;
            rxCnt   <= '0;
            rxIdx   <= '0;
            rxShift <= '0;
            rxPar   <= 1'b0;
        end else begin
            rxSync1 <= RxD;
            rxSync2 <= rxSync1;
            rxState <= rxStateNext;
            rxCnt   <= rxCntNext;
            rxIdx   <= rxIdxNext;
            rxShift <= rxShiftNext;
            rxPar   <= rxParNext;
        end
    end

    always_comb begin
        rxStateNext = rxState;
        rxCntNext   = rxCnt - 1'b1;
        rxIdxNext   = rxIdx;
        rxShiftNext = rxShift;
        rxParNext   = rxPar;
        frameDone   = 1'b0;
        case (rxState)
            Idle: begin
                rxCntNext = CntHalf;
                if (!rxSync2) rxStateNext = Start;
            end
            // A start bit that is high again at mid-bit was a glitch.
            Start: if (rxCnt == '0) begin
                rxCntNext   = CntBit;
                rxIdxNext   = '0;
                rxStateNext = rxSync2 ? Idle : Data;
            end
            Data: if (rxCnt == '0) begin
                rxCntNext   = CntBit;
                rxShiftNext = {rxSync2, rxShift[DataBits-1:1]};
                if (rxIdx == LastBit) rxStateNext = ParityOn ? Par : Stop;
                else                  rxIdxNext   = rxIdx + 1'b1;
            end
            Par: if (rxCnt == '0) begin
                rxCntNext   = CntBit;
                rxParNext   = rxSync2;
                rxStateNext = Stop;
            end
            Stop: if (rxCnt == '0) begin
                rxCntNext   = CntHalf;
                frameDone   = 1'b1;
                rxStateNext = Idle;
            end
            default: rxStateNext = Idle;
        endcase
    end

    // --------------------------------------------------------- FIFO and error flags
    logic [DataBits-1:0] fifoMem [RxFifoDepth];
    logic [AW:0]         wptr, rptr;
    logic                fifoFull, pop, fifoWrite;
    logic                setFrameErr, setParityErr, setOverrun, goodFrame;

    assign setFrameErr  = frameDone & ~rxSync2;
    assign setParityErr = frameDone & rxSync2 & ParityOn & (rxPar != parityOf(rxShift));
    assign goodFrame    = frameDone & rxSync2 & ~setParityErr;

    assign fifoFull   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rx_valid   = (wptr != rptr);
    assign rx_count   = wptr - rptr;
    assign pop        = rx_valid & rx_ready;
    assign fifoWrite  = goodFrame & (~fifoFull | pop);
    assign setOverrun = goodFrame & fifoFull & ~pop;

    // NOTE: FIFO storage is not reset; rx_data is masked while empty so its reset value is still 0.
    assign rx_data = rx_valid ? fifoMem[rptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (fifoWrite) fifoMem[wptr[AW-1:0]] <= rxShift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (fifoWrite) wptr <= wptr + 1'b1;
            if (pop)       rptr <= rptr + 1'b1;
            rx_frame_err  <= setFrameErr  | (rx_frame_err  & ~err_clear);
            rx_parity_err <= setParityErr | (rx_parity_err & ~err_clear);
            rx_overrun    <= setOverrun   | (rx_overrun    & ~err_clear);
        end
    end

endmodule
